// File: rtl/updown_counter.sv
// updown_counter: loadable up/down counter with cascade enables, combinational RCO and registered WRAP.
// Define UPDOWN_AUTO_RELOAD_EN to reload Din instead of wrapping when stepping from the terminal value.
module updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic             nLOAD,
    input  logic             UnD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             RCO,
    output logic             WRAP
);
    localparam logic [WIDTH-1:0] ONE = 1;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             at_term;
    assign at_term = UnD ? &cnt_q : ~|cnt_q;
    assign RCO     = ENT & at_term;
    assign Dout    = cnt_q;
    assign WRAP    = wrap_q;
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (!nLOAD) begin
            cnt_d = Din;
        end else if (ENP && ENT) begin
            wrap_d = at_term;
`ifdef UPDOWN_AUTO_RELOAD_EN
            cnt_d  = at_term ? Din : (UnD ? cnt_q + ONE : cnt_q - ONE);
`else
            cnt_d  = UnD ? cnt_q + ONE : cnt_q - ONE;
`endif
        end
    end
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed scoreboard bench for updown_counter (single stage and 8-bit cascade).
module tb_updown_counter;
    logic       clk = 1'b0;
    logic       nclr, nload, und, enp, ent;
    logic [3:0] din, dout;
    logic       rco, wrap;
    logic       c_nload, c_und, c_enp;
    logic [7:0] c_din;
    logic [3:0] lo_dout, hi_dout;
    logic       lo_rco, hi_rco, lo_wrap, hi_wrap;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string      name;
        bit         casc;
        logic [7:0] dout;
        logic       rco;
        logic       wrap;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4)) u_dut (
        .CLK(clk), .nCLR(nclr), .nLOAD(nload), .UnD(und), .ENP(enp), .ENT(ent),
        .Din(din), .Dout(dout), .RCO(rco), .WRAP(wrap)
    );
    updown_counter #(.WIDTH(4)) u_lo (
        .CLK(clk), .nCLR(nclr), .nLOAD(c_nload), .UnD(c_und), .ENP(c_enp), .ENT(1'b1),
        .Din(c_din[3:0]), .Dout(lo_dout), .RCO(lo_rco), .WRAP(lo_wrap)
    );
    updown_counter #(.WIDTH(4)) u_hi (
        .CLK(clk), .nCLR(nclr), .nLOAD(c_nload), .UnD(c_und), .ENP(c_enp), .ENT(lo_rco),
        .Din(c_din[7:4]), .Dout(hi_dout), .RCO(hi_rco), .WRAP(hi_wrap)
    );

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    initial begin
        exp_t       e;
        logic [7:0] a_d;
        logic       a_r, a_w;
        forever begin
            wait (q.size() > 0);
            e   = q.pop_front();
            a_d = e.casc ? {hi_dout, lo_dout} : {4'h0, dout};
            a_r = e.casc ? hi_rco : rco;
            a_w = e.casc ? lo_wrap : wrap;
            checks++;
            if (a_d !== e.dout || a_r !== e.rco || a_w !== e.wrap) begin
                errors++;
                $display("FAIL %s: got dout=%h rco=%b wrap=%b, expected dout=%h rco=%b wrap=%b",
                         e.name, a_d, a_r, a_w, e.dout, e.rco, e.wrap);
            end
        end
    end

    task automatic push(input string n, input bit c, input logic [7:0] d, input logic r, input logic w);
        exp_t e;
        e.name = n; e.casc = c; e.dout = d; e.rco = r; e.wrap = w;
        q.push_back(e);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        nclr = 1'b1; nload = 1'b1; und = 1'b1; enp = 1'b0; ent = 1'b1; din = 4'h0;
        c_nload = 1'b1; c_und = 1'b0; c_enp = 1'b0; c_din = 8'h00;
        #2 nclr = 1'b0;
        #1 push("reset_up", 0, 8'h00, 1'b0, 1'b0);
        und = 1'b0;
        push("reset_dn_rco", 0, 8'h00, 1'b1, 1'b0);
        push("reset_casc", 1, 8'h00, 1'b1, 1'b0);
        step();
        nclr = 1'b1;
        nload = 1'b0; din = 4'hA; ent = 1'b0; und = 1'b1;
        step(); push("load_a_no_en", 0, 8'h0A, 1'b0, 1'b0);
        din = 4'hE; ent = 1'b1;
        step(); push("up_load_e", 0, 8'h0E, 1'b0, 1'b0);
        nload = 1'b1; enp = 1'b1;
        step(); push("up_f", 0, 8'h0F, 1'b1, 1'b0);
        step(); push("up_wrap_0", 0, 8'h00, 1'b0, 1'b1);
        step(); push("up_1", 0, 8'h01, 1'b0, 1'b0);
        nload = 1'b0; din = 4'h1; und = 1'b0;
        step(); push("dn_load_1", 0, 8'h01, 1'b0, 1'b0);
        nload = 1'b1;
        step(); push("dn_0", 0, 8'h00, 1'b1, 1'b0);
        und = 1'b1;
        #1 push("dir_toggle_rco", 0, 8'h00, 1'b0, 1'b0);
        und = 1'b0;
        #1 push("dir_back_rco", 0, 8'h00, 1'b1, 1'b0);
        step(); push("dn_wrap_f", 0, 8'h0F, 1'b0, 1'b1);
        step(); push("dn_e", 0, 8'h0E, 1'b0, 1'b0);
        nload = 1'b0; din = 4'h0;
        step(); push("gate_load_0", 0, 8'h00, 1'b1, 1'b0);
        nload = 1'b1; enp = 1'b0;
        step(); push("enp0_hold", 0, 8'h00, 1'b1, 1'b0);
        ent = 1'b0;
        #1 push("ent0_rco", 0, 8'h00, 1'b0, 1'b0);
        step(); push("ent0_hold", 0, 8'h00, 1'b0, 1'b0);
        ent = 1'b1; enp = 1'b1; nload = 1'b0; din = 4'h5;
        step(); push("load_beats_count", 0, 8'h05, 1'b0, 1'b0);
        din = 4'h3;
        step(); push("div_load_3", 0, 8'h03, 1'b0, 1'b0);
        nload = 1'b1;
        step(); push("div_2", 0, 8'h02, 1'b0, 1'b0);
        step(); push("div_1", 0, 8'h01, 1'b0, 1'b0);
        step(); push("div_0", 0, 8'h00, 1'b1, 1'b0);
`ifdef UPDOWN_AUTO_RELOAD_EN
        step(); push("div_reload_3", 0, 8'h03, 1'b0, 1'b1);
        step(); push("div_2_again", 0, 8'h02, 1'b0, 1'b0);
        step(); push("div_1_again", 0, 8'h01, 1'b0, 1'b0);
        step(); push("div_0_again", 0, 8'h00, 1'b1, 1'b0);
        step(); push("div_reload_3b", 0, 8'h03, 1'b0, 1'b1);
`else
        step(); push("div_wrap_f", 0, 8'h0F, 1'b0, 1'b1);
`endif
        nclr = 1'b0;
        #1 push("async_clear", 0, 8'h00, 1'b1, 1'b0);
        step();
        nclr = 1'b1; enp = 1'b0;
        c_nload = 1'b0; c_din = 8'h01; c_und = 1'b0; c_enp = 1'b1;
        step(); push("casc_load_01", 1, 8'h01, 1'b0, 1'b0);
        c_nload = 1'b1;
        step(); push("casc_00", 1, 8'h00, 1'b1, 1'b0);
        step(); push("casc_wrap_ff", 1, 8'hFF, 1'b0, 1'b1);
        step(); push("casc_fe", 1, 8'hFE, 1'b0, 1'b0);
        c_nload = 1'b0; c_din = 8'h0F; c_und = 1'b1;
        step(); push("casc_load_0f", 1, 8'h0F, 1'b0, 1'b0);
        c_nload = 1'b1;
        step(); push("casc_up_10", 1, 8'h10, 1'b0, 1'b1);
        step(); push("casc_up_11", 1, 8'h11, 1'b0, 1'b0);
        #5;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
